// File: rtl/layer_scheduler.sv
// Time-multiplexes one shared Perceptron across the M neurons of a layer:
// latch inputs, fetch each weight row, evaluate, and stream results in order.
module layer_scheduler #(
  parameter  int N          = 4,
  parameter  int M          = 8,
  parameter  int DATA_WIDTH = 16,
  localparam int IW         = $clog2(M)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic signed [DATA_WIDTH-1:0] x_in_i [N],
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         wmem_en_o,
  output logic        [IW-1:0]         wmem_addr_o,
  input  logic signed [DATA_WIDTH-1:0] wmem_w_i [N],
  input  logic signed [DATA_WIDTH-1:0] wmem_b_i,
  output logic signed [DATA_WIDTH-1:0] pe_x_o [N],
  output logic signed [DATA_WIDTH-1:0] pe_w_o [N],
  output logic signed [DATA_WIDTH-1:0] pe_b_o,
  input  logic signed [DATA_WIDTH-1:0] pe_y_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic        [IW-1:0]         out_idx_o,
  output logic                         out_last_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_EVAL, S_EMIT, S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  state_t                         state_q, state_d;
  logic        [IW-1:0]           idx_q, idx_d;
  logic                           busy_q, done_q, wmem_en_q, out_valid_q;
  logic        [IW-1:0]           wmem_addr_q, out_idx_q;
  logic signed [DATA_WIDTH-1:0]   pe_x_q [N];
  logic signed [DATA_WIDTH-1:0]   pe_w_q [N];
  logic signed [DATA_WIDTH-1:0]   pe_b_q, out_data_q;
  logic                           load_x, load_w, capture;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_x  = 1'b0;
    load_w  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
          load_x  = 1'b1;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_EVAL;
        load_w  = 1'b1;
      end
      S_EVAL: begin
        state_d = S_EMIT;
        capture = 1'b1;
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition outside IDLE and suppresses any capture.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      load_w  = 1'b0;
      capture = 1'b0;
    end
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wmem_en_q   <= 1'b0;
      wmem_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      pe_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                     (state_d == S_EVAL)  || (state_d == S_EMIT);
      done_q      <= (state_d == S_DONE);
      wmem_en_q   <= (state_d == S_FETCH);
      out_valid_q <= (state_d == S_EMIT);
      if (state_d == S_FETCH) wmem_addr_q <= idx_d;
      if (load_w)             pe_b_q      <= wmem_b_i;
      if (capture) begin
        out_data_q <= pe_y_i;
        out_idx_q  <= idx_q;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pe_x_q[gi] <= '0;
          pe_w_q[gi] <= '0;
        end else begin
          if (load_x) pe_x_q[gi] <= x_in_i[gi];
          if (load_w) pe_w_q[gi] <= wmem_w_i[gi];
        end
      end
      assign pe_x_o[gi] = pe_x_q[gi];
      assign pe_w_o[gi] = pe_w_q[gi];
    end
  endgenerate

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wmem_en_o   = wmem_en_q;
  assign wmem_addr_o = wmem_addr_q;
  assign pe_b_o      = pe_b_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_valid_q && (out_idx_q == LAST_IDX);

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: weight memory and Perceptron models around the DUT,
// with a result scoreboard filled at start and drained on each handshake.
module tb_layer_scheduler;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 16;
  localparam int IW = $clog2(M);

  typedef struct {
    logic signed [DW-1:0] data;
    int                   idx;
  } exp_t;

  logic                 clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic signed [DW-1:0] x_in [N];
  logic signed [DW-1:0] wmem_w [N];
  logic signed [DW-1:0] wmem_b;
  logic signed [DW-1:0] pe_x [N];
  logic signed [DW-1:0] pe_w [N];
  logic signed [DW-1:0] pe_b, pe_y, out_data;
  logic                 busy, done, wmem_en, out_valid, out_last;
  logic [IW-1:0]        wmem_addr, out_idx;

  logic signed [DW-1:0] mem_w [M][N];
  logic signed [DW-1:0] mem_b [M];
  logic signed [DW-1:0] cur_x [N];
  exp_t                 sb [$];
  exp_t                 mon_e;
  int                   vectors = 0, miscompares = 0;
  int                   pe_acc;

  layer_scheduler #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .x_in_i(x_in),
    .busy_o(busy), .done_o(done), .wmem_en_o(wmem_en), .wmem_addr_o(wmem_addr),
    .wmem_w_i(wmem_w), .wmem_b_i(wmem_b), .pe_x_o(pe_x), .pe_w_o(pe_w),
    .pe_b_o(pe_b), .pe_y_i(pe_y), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_idx_o(out_idx), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  // One-cycle-latency weight memory.
  always @(posedge clk) begin
    if (wmem_en) begin
      for (int i = 0; i < N; i++) wmem_w[i] <= mem_w[wmem_addr][i];
      wmem_b <= mem_b[wmem_addr];
    end
  end

  // Combinational Perceptron with ReLU.
  always_comb begin
    pe_acc = int'(pe_b);
    for (int i = 0; i < N; i++) pe_acc = pe_acc + int'(pe_x[i]) * int'(pe_w[i]);
    pe_y = (pe_acc < 0) ? '0 : DW'(pe_acc);
  end

  function automatic logic signed [DW-1:0] model_y(int k);
    int acc;
    acc = int'(mem_b[k]);
    for (int i = 0; i < N; i++) acc = acc + int'(cur_x[i]) * int'(mem_w[k][i]);
    return (acc < 0) ? '0 : DW'(acc);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL result_unexpected: got idx=%0d data=%0d, required no output", out_idx, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_idx !== IW'(mon_e.idx) || out_last !== (mon_e.idx == M - 1)) begin
          miscompares++;
          $display("FAIL result: got idx=%0d data=%0d last=%0b, required idx=%0d data=%0d last=%0b",
                   out_idx, out_data, out_last, mon_e.idx, mon_e.data, (mon_e.idx == M - 1));
        end
      end
    end
  end

  task automatic fill_mem_ones();
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < N; i++) mem_w[k][i] = 16'sd1;
      mem_b[k] = DW'(k);
    end
    for (int i = 0; i < N; i++) cur_x[i] = DW'(i + 1);
  endtask

  // Push the layer's expected results, then pulse start; returns in cycle 1.
  task automatic do_start();
    for (int i = 0; i < N; i++) x_in[i] = cur_x[i];
    for (int k = 0; k < M; k++) sb.push_back('{model_y(k), k});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, wmem_en, out_valid, out_last} !== 5'b0 || wmem_addr !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy=%b done=%b en=%b valid=%b last=%b addr=%0d idx=%0d, required all 0",
               busy, done, wmem_en, out_valid, out_last, wmem_addr, out_idx);
    end
    vectors++;
    if (out_data !== '0 || pe_b !== '0 || pe_x[0] !== '0 || pe_w[N-1] !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got out_data=%0d pe_b=%0d pe_x0=%0d pe_w3=%0d, required 0",
               out_data, pe_b, pe_x[0], pe_w[N-1]);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int first_en = -1, first_v = -1, done_cyc = -1, done_cnt = 0, last_cnt = 0;
    fill_mem_ones();
    do_start();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (wmem_en && first_en < 0) first_en = cyc;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_last) last_cnt++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      @(posedge clk); #1;
    end
    vectors++;
    if (first_en != 1 || first_v != 4) begin
      miscompares++;
      $display("FAIL normal_latency: got wmem_en cycle %0d out_valid cycle %0d, required 1 and 4", first_en, first_v);
    end
    vectors++;
    if (done_cyc != 17 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL normal_done: got cycle %0d count %0d, required cycle 17 count 1", done_cyc, done_cnt);
    end
    vectors++;
    if (last_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL normal_stream: got last cycles %0d pending %0d, required 1 and 0", last_cnt, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int done_cyc = -1, stall = 0, bad_hold = 0;
    bit bp_done = 0;
    fill_mem_ones();
    do_start();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (out_valid && out_idx == IW'(1) && !bp_done) begin
        if (stall < 3) begin
          out_ready = 1'b0;
          if (out_data !== 16'sd11 || out_idx !== IW'(1) || wmem_en !== 1'b0) bad_hold++;
          stall++;
        end else begin
          out_ready = 1'b1;
          bp_done   = 1;
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    vectors++;
    if (bad_hold != 0 || stall != 3) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d bad stalled cycles over %0d stalls, required 0 over 3", bad_hold, stall);
    end
    vectors++;
    if (done_cyc != 20 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_done: got cycle %0d pending %0d, required cycle 20 pending 0", done_cyc, sb.size());
    end
  endtask

  task automatic test_negative();
    int done_cyc = -1;
    fill_mem_ones();
    for (int i = 0; i < N; i++) begin
      mem_w[0][i] = -16'sd1;
      mem_w[1][i] = 16'sd2;
    end
    mem_b[0] = 16'sd0;
    mem_b[1] = -16'sd3;
    do_start();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 3) begin
        vectors++;
        if (pe_w[0] !== -16'sd1 || pe_w[N-1] !== -16'sd1 || pe_b !== 16'sd0) begin
          miscompares++;
          $display("FAIL neg_row0: got pe_w0=%0d pe_w3=%0d pe_b=%0d, required -1 -1 0", pe_w[0], pe_w[N-1], pe_b);
        end
      end
      if (cyc == 7) begin
        vectors++;
        if (pe_w[0] !== 16'sd2 || pe_b !== -16'sd3) begin
          miscompares++;
          $display("FAIL neg_row1: got pe_w0=%0d pe_b=%0d, required 2 -3", pe_w[0], pe_b);
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cyc != 17 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL neg_done: got cycle %0d pending %0d, required cycle 17 pending 0", done_cyc, sb.size());
    end
  endtask

  task automatic test_start_busy();
    int done_cnt = 0, bad_x = 0;
    fill_mem_ones();
    do_start();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 11) begin
        for (int i = 0; i < N; i++) x_in[i] = 16'sd9;
        start = 1'b1;
      end
      if (cyc == 12) start = 1'b0;
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) if (pe_x[i] !== cur_x[i]) bad_x++;
    vectors++;
    if (bad_x != 0 || done_cnt != 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL start_busy: got %0d changed pe_x lanes, %0d done, %0d pending, required 0 1 0",
               bad_x, done_cnt, sb.size());
    end
  endtask

  task automatic test_abort();
    int abort_cyc = -1, done_cnt = 0, done_cyc = -1;
    fill_mem_ones();
    do_start();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (abort_cyc < 0 && out_valid && out_idx == IW'(1)) begin
        out_ready = 1'b0;
        abort     = 1'b1;
        abort_cyc = cyc;
      end else if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        abort = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_exit: got out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
      end
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (abort_cyc != 8 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_done: got abort cycle %0d done count %0d, required 8 and 0", abort_cyc, done_cnt);
    end
    sb.delete();
    out_ready = 1'b1;
    do_start();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cyc != 17 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL abort_restart: got done cycle %0d pending %0d, required 17 and 0", done_cyc, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    fill_mem_ones();
    do_start();
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (busy !== 1'b1 || wmem_addr !== IW'(2)) begin
      miscompares++;
      $display("FAIL rst_pre: got busy=%b addr=%0d, required 1 and 2", busy, wmem_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, wmem_en, out_valid, out_last} !== 5'b0 || wmem_addr !== '0 ||
        pe_x[0] !== '0 || pe_w[0] !== '0 || pe_b !== '0 || out_data !== '0 || out_idx !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got busy=%b en=%b addr=%0d pe_x0=%0d pe_w0=%0d pe_b=%0d data=%0d, required all 0",
               busy, wmem_en, wmem_addr, pe_x[0], pe_w[0], pe_b, out_data);
    end
    sb.delete();
    @(negedge clk) rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      if (busy || wmem_en || out_valid || done) activity++;
    end
    vectors++;
    if (activity != 0) begin
      miscompares++;
      $display("FAIL rst_idle: got %0d active cycles after release, required 0", activity);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) x_in[i] = '0;
    test_reset();
    test_normal();
    test_backpressure();
    test_negative();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Time-multiplexes a single Perceptron datapath across the M neurons of one fully-connected layer. On `start`, the block latches the layer input vector. For each neuron index it then fetches that neuron's weights and bias from an external weight memory, drives them into the shared Perceptron, and captures the activated result. Results are streamed out over a valid/ready handshake in neuron order. The block sits between the weight memory, the Perceptron instance and the next-layer buffer.

## Interface
- `N`, 4, inputs per neuron (Perceptron dimensionality)
- `M`, 8, neurons per layer; M >= 2
- `IW`, $clog2(M), neuron index width (derived, not overridden)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a layer; accepted only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE, no `done`
- `x_in`  in  N x `DATA_WIDTH` signed  layer input vector, sampled on accepted `start`
- `busy`  out  1  high in FETCH, LOAD, EVAL, EMIT
- `done`  out  1  one-cycle pulse after the last result handshake
- `wmem_en`  out  1  weight-memory read strobe
- `wmem_addr`  out  IW  neuron index being fetched
- `wmem_w`  in  N x `DATA_WIDTH` signed  weight row, valid the cycle after `wmem_en`
- `wmem_b`  in  `DATA_WIDTH` signed  bias, same timing as `wmem_w`
- `pe_x`  out  N x `DATA_WIDTH` signed  Perceptron input vector (latched)
- `pe_w`  out  N x `DATA_WIDTH` signed  Perceptron weights (registered)
- `pe_b`  out  `DATA_WIDTH` signed  Perceptron bias (registered)
- `pe_y`  in  `DATA_WIDTH` signed  Perceptron activated output (combinational from `pe_*`)
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  `DATA_WIDTH` signed  captured `pe_y`
- `out_idx`  out  IW  neuron index of `out_data`
- `out_last`  out  1  `out_idx == M-1` while `out_valid`

## Operation
- States: IDLE, FETCH, LOAD, EVAL, EMIT, DONE.
- IDLE: on `start`, latch `x_in` into `pe_x`, clear `idx` to 0, go to FETCH. `start` in any other state is ignored.
- FETCH: `wmem_en=1`, `wmem_addr=idx`. Go to LOAD.
- LOAD: register `wmem_w`/`wmem_b` into `pe_w`/`pe_b`. Go to EVAL.
- EVAL: `pe_*` are stable. Capture `pe_y` into `out_data` and `idx` into `out_idx`. Go to EMIT.
- EMIT: `out_valid=1`. On `out_valid & out_ready`:
  - if `idx==M-1`, go to DONE;
  - otherwise `idx<=idx+1` and go to FETCH.
- DONE: `done=1` for exactly one cycle, `busy=0`. Go to IDLE. `start` in DONE is ignored.
- `abort` has priority over every transition in every non-IDLE state: next state IDLE, `out_valid` drops next cycle, no `done`. `abort` in IDLE is a no-op.
- `out_data`, `out_idx` and `out_last` hold stable while `out_valid & !out_ready`. `out_valid` never drops without a handshake, except on `abort` or `rst`.
- `idx` never exceeds M-1. There is no wrap: the transition from M-1 always leads to DONE. For non-power-of-two M, unused index codes are never driven.
- `pe_x` holds its value across the whole layer and after it; it changes only on an accepted `start`.
- No arithmetic is performed in this block. All widths pass through unchanged, and signedness is preserved.

## Timing
- Reset values: `busy=0`, `done=0`, `wmem_en=0`, `wmem_addr=0`, `pe_x/pe_w/pe_b=0`, `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, state IDLE.
- Reset asserted mid-layer clears everything immediately (asynchronously). After `rst` deasserts, the block waits in IDLE for a new `start`; there is no resume.
- Cycle timing for the first neuron (`start` sampled at edge 0):
  - cycle 1: FETCH, `wmem_en=1`;
  - cycle 2: LOAD;
  - cycle 3: EVAL;
  - cycle 4: `out_valid=1` first asserted.
- Each neuron costs 4 cycles plus any backpressure cycles.
- Full layer with `out_ready` held high: `done` is asserted in cycle 4M+1 after the `start` edge.
- Weight memory latency is fixed at exactly 1 cycle. `wmem_w`/`wmem_b` are ignored outside LOAD.
- All outputs are registered, except `out_last`, which is decoded from registered `out_idx` and `out_valid`.

## Test plan
- Normal layer, M=4, N=4: memory row k = weights {1,1,1,1}, bias k; `x_in={1,2,3,4}`; `out_ready=1` -> results 10,11,12,13 at `out_idx` 0..3; `out_last` only on idx 3; `done` pulse in cycle 17.
- Backpressure: same stimulus with `out_ready` low for 3 cycles on idx 1 -> `out_data=11`, `out_idx=1` held constant; no FETCH for idx 2 until the handshake; `done` delayed by 3 cycles.
- Negative and ReLU path: row 0 weights {-1,-1,-1,-1}, bias 0, `x_in={1,2,3,4}` -> `out_data=0` on idx 0; no sign corruption on `pe_w`/`pe_b`.
- Start while busy: pulse `start` with a new `x_in` during EVAL of idx 2 -> ignored; `pe_x` unchanged; exactly M results and one `done`.
- Abort: assert `abort` in EMIT of idx 1 with `out_ready=0` -> IDLE next cycle, `out_valid=0`, no `done`; a new `start` restarts at idx 0.
- Reset mid-layer: assert `rst` during LOAD of idx 2 -> all outputs reach their reset values without waiting for a clock edge; after release, no activity until `start`.
